// File: rtl/logic_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_pkg
// Description : Shared definitions for the logic gate unit: the 3-bit gate
//               opcode enumeration and the default operand / counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_gate_pkg;

    // Default operand/result width and transaction counter width.
    localparam int LGU_WIDTH = 8;
    localparam int LGU_CNT_W = 16;

    // Gate select encoding carried on in_op / out_op.
    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_BUF  = 3'd7
    } gate_op_e;

endpackage : logic_gate_pkg
`default_nettype wire

// File: rtl/logic_gate_core.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_core
// Description : Purely combinational bitwise gate. Selects one of eight
//               operations on a and b; b is unused for NOT and BUF.
// Ports       : op [2:0]       gate select (gate_op_e)
//               a, b [WIDTH]   operands
//               y [WIDTH]      bitwise result
// Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = LGU_WIDTH
) (
    input  gate_op_e           op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   y
);

    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_BUF:  y = a;
            default: y = '0;
        endcase
    end

endmodule : logic_gate_core
`default_nettype wire

// File: rtl/logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_unit
// Description : Bitwise gate unit with a valid/ready input, a single-slot
//               registered output (1-cycle latency, full throughput), an
//               accepted-transaction counter and optional result reductions.
// Ports       : clk, rst_n                  clock, async active-low reset
//               in_valid/in_ready           input handshake
//               in_op[2:0], in_a, in_b      opcode and operands
//               out_valid/out_ready         output handshake
//               out_y, out_op[2:0]          registered result and its opcode
//               out_red[2:0]                {^y, |y, &y} of out_y
//               txn_count[CNT_W]            accepted transactions (wrapping)
// Config      : LOGIC_GATE_UNIT_REDUCE_EN - when defined out_red is
//               registered with the result; otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = LGU_WIDTH,
    parameter int CNT_W = LGU_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y,
    output logic [2:0]         out_op,
    output logic [2:0]         out_red,
    output logic [CNT_W-1:0]   txn_count
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state;
    logic             accept;
    logic [WIDTH-1:0] gate_y;

    // The slot can take a new result whenever it is empty or is being drained
    // this cycle; this gives one result per cycle with no bubble.
    assign out_valid = (state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    logic_gate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (gate_op_e'(in_op)),
        .a  (in_a),
        .b  (in_b),
        .y  (gate_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            out_y     <= '0;
            out_op    <= '0;
            txn_count <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (accept)                 state <= ST_FULL;
                ST_FULL:  if (out_ready && !accept)   state <= ST_EMPTY;
                default:                              state <= ST_EMPTY;
            endcase
            // Operands are captured only on accept, so the held result stays
            // stable while the consumer stalls.
            if (accept) begin
                out_y     <= gate_y;
                out_op    <= in_op;
                txn_count <= txn_count + 1'b1;
            end
        end
    end

`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_red <= 3'b000;
        end else if (accept) begin
            out_red <= {^gate_y, |gate_y, &gate_y};
        end
    end
`else
    assign out_red = 3'b000;
`endif

endmodule : logic_gate_unit
`default_nettype wire

// File: tb/tb_logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_gate_unit
// Description : Self-checking bench for logic_gate_unit (WIDTH=8, CNT_W=4).
//               Directed scenarios plus random traffic, compared against a
//               transaction-level reference model of the output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_gate_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [2:0]       out_op;
    logic [2:0]       out_red;
    logic [CNT_W-1:0] txn_count;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the output slot should hold.
    bit               m_valid;
    logic [WIDTH-1:0] m_y;
    logic [2:0]       m_op;
    logic [2:0]       m_red;
    int               m_cnt;

    always #5 clk = ~clk;

    logic_gate_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_op    (out_op),
        .out_red   (out_red),
        .txn_count (txn_count)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_gate(input int op, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            0: r = ~a;
            1: r = a & b;
            2: r = a | b;
            3: r = ~(a & b);
            4: r = ~(a | b);
            5: r = a ^ b;
            6: r = ~(a ^ b);
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] ref_red(input logic [WIDTH-1:0] y);
        int ones = 0;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        for (int i = 0; i < WIDTH; i++) ones += int'(y[i]);
        return {ones % 2 == 1, ones > 0, ones == WIDTH};
`else
        return 3'b000;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_y     = '0;
        m_op    = '0;
        m_red   = '0;
        m_cnt   = 0;
    endtask

    // One clock cycle: drive inputs, check in_ready before the edge, advance
    // the model at the edge, then check outputs 1 time unit later.
    task automatic step(input bit v, input int op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit rdy);
        bit exp_ready;
        in_valid  = v;
        in_op     = op[2:0];
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        exp_ready = !m_valid || rdy;
        @(negedge clk);
        check_val("in_ready", 64'(in_ready), 64'(exp_ready));
        if (m_valid) begin
            check_val("pre_y", 64'(out_y), 64'(m_y));
            check_val("pre_op", 64'(out_op), 64'(m_op));
        end
        @(posedge clk);
        if (v && exp_ready) begin
            m_valid = 1;
            m_y     = ref_gate(op, a, b);
            m_op    = op[2:0];
            m_red   = ref_red(m_y);
            m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        end else if (rdy) begin
            m_valid = 0;
        end
        #1;
        check_val("out_valid", 64'(out_valid), 64'(m_valid));
        check_val("txn_count", 64'(txn_count), 64'(m_cnt));
        if (m_valid) begin
            check_val("out_y", 64'(out_y), 64'(m_y));
            check_val("out_op", 64'(out_op), 64'(m_op));
            check_val("out_red", 64'(out_red), 64'(m_red));
        end
    endtask

    logic [WIDTH-1:0] walk_exp [8];

    initial begin
        walk_exp = '{8'h3A, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hC5};
        rst_n = 1'b0; in_valid = 1'b1; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_txn_count", 64'(txn_count), 64'd0);
        check_val("rst_out_y", 64'(out_y), 64'd0);
        check_val("rst_out_red", 64'(out_red), 64'd0);
        rst_n = 1'b1;

        // Walk all opcodes with fixed operands.
        for (int op = 0; op < 8; op++) begin
            step(1, op, 8'hC5, 8'h3A, 1);
            check_val("walk_y", 64'(out_y), 64'(walk_exp[op]));
        end
        check_val("walk_count", 64'(txn_count), 64'd8);

        // Back-to-back stream: full throughput.
        for (int i = 0; i < 4; i++) begin
            step(1, i + 1, 8'h96, 8'h5A, 1);
            check_val("b2b_valid", 64'(out_valid), 64'd1);
        end

        // Stall with held result; new input must be ignored.
        step(0, 0, 8'h00, 8'h00, 1);
        step(1, 1, 8'hF0, 8'h3C, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 2, 8'h11, 8'h22, 0);
            check_val("stall_y", 64'(out_y), 64'h30);
            check_val("stall_in_ready", 64'(in_ready), 64'd0);
        end
        step(0, 0, 8'h00, 8'h00, 1);
        check_val("drained", 64'(out_valid), 64'd0);

        // Reduction outputs for XOR(0F,01) = 0E.
        step(1, 5, 8'h0F, 8'h01, 0);
        check_val("xor_y", 64'(out_y), 64'h0E);
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        check_val("xor_red", 64'(out_red), 64'b110);
`else
        check_val("xor_red", 64'(out_red), 64'b000);
`endif

        // Asynchronous reset while a result is pending.
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'd0);
        check_val("arst_txn_count", 64'(txn_count), 64'd0);
        check_val("arst_out_y", 64'(out_y), 64'd0);
        check_val("arst_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("arst_no_accept", 64'(txn_count), 64'd0);
        model_reset();
        rst_n = 1'b1;
        step(1, 7, 8'hA5, 8'h00, 1);
        check_val("post_rst_count", 64'(txn_count), 64'd1);

        // Counter wrap at CNT_W=4: 16th accept -> 0, 17th -> 1.
        for (int i = 0; i < 15; i++) step(1, i % 8, 8'(i), 8'(i * 3), 1);
        check_val("wrap_zero", 64'(txn_count), 64'd0);
        step(1, 3, 8'h12, 8'h34, 1);
        check_val("wrap_one", 64'(txn_count), 64'd1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(1)), int'($urandom_range(7)), 8'($urandom),
                 8'($urandom), bit'($urandom_range(3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_logic_gate_unit
`default_nettype wire
